// File: rtl/vga_sync_gen.sv
// VGA sync generator: 640x480@60 Hz timing from a divided system clock.
// Produces a pixel-clock enable, pixel coordinates, active-video flag,
// registered active-low syncs and line/frame end pulses.
module vga_sync_gen #(
    parameter int CLK_DIV = 2,
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    // A 1-bit divider is kept for CLK_DIV=1 so the register never has zero width;
    // it then sits at 0 and the enable is permanently asserted.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP_END   = 10'(H_DISP);
    localparam logic [9:0] V_DISP_END   = 10'(V_DISP);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISP + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISP + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [9:0]       r_h_cnt;
    logic [9:0]       r_v_cnt;
    logic [9:0]       w_h_nxt;
    logic [9:0]       w_v_nxt;
    logic             r_hsync;
    logic             r_vsync;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             w_p_tick;
    logic             w_h_end;
    logic             w_v_end;

    assign w_p_tick = (r_div_cnt == DIV_LAST);
    assign w_h_end  = (r_h_cnt == H_LAST);
    assign w_v_end  = (r_v_cnt == V_LAST);

    // Next-state: divider wraps on the enable, h advances on the enable,
    // v advances on the h wrap; syncs are decoded from the next counts so the
    // registered sync lines up with the registered coordinates.
    always_comb begin
        w_div_nxt   = r_div_cnt;
        w_h_nxt     = r_h_cnt;
        w_v_nxt     = r_v_cnt;
        w_hsync_nxt = 1'b1;
        w_vsync_nxt = 1'b1;

        if (w_p_tick) begin
            w_div_nxt = '0;
        end else begin
            w_div_nxt = r_div_cnt + 1'b1;
        end

        if (w_p_tick) begin
            if (w_h_end) begin
                w_h_nxt = '0;
                if (w_v_end) begin
                    w_v_nxt = '0;
                end else begin
                    w_v_nxt = r_v_cnt + 10'd1;
                end
            end else begin
                w_h_nxt = r_h_cnt + 10'd1;
            end
        end

        if ((w_h_nxt >= H_SYNC_FIRST) && (w_h_nxt <= H_SYNC_LAST)) begin
            w_hsync_nxt = 1'b0;
        end
        if ((w_v_nxt >= V_SYNC_FIRST) && (w_v_nxt <= V_SYNC_LAST)) begin
            w_vsync_nxt = 1'b0;
        end
    end

    // State registers; reset parks the raster at (0,0) with both syncs idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_h_cnt   <= w_h_nxt;
            r_v_cnt   <= w_v_nxt;
            r_hsync   <= w_hsync_nxt;
            r_vsync   <= w_vsync_nxt;
        end
    end

    assign p_tick     = w_p_tick;
    assign pixel_x    = r_h_cnt;
    assign pixel_y    = r_v_cnt;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = (r_h_cnt < H_DISP_END) && (r_v_cnt < V_DISP_END);
    assign line_tick  = w_p_tick && w_h_end;
    assign frame_tick = w_p_tick && w_h_end && w_v_end;

endmodule
